uart_fifo_mmio: RTL and testbench
=================================

// Module: uart_fifo_mmio
// PURPOSE
//  Memory-mapped full-duplex UART with parametrised frame format and TX/RX FIFOs; successor to the single-byte UART peripheral.
//  Sits on the single-cycle core's data bus (Address/DataIn/DataOut/Select/Write).
//  Adds per-direction FIFOs, selectable parity and stop bits, sticky error flags and an interrupt line.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock in Hz; used only for DFLT_DIV
//  BAUD_RATE   9_600       baud rate applied at reset
//  DFLT_DIV    CLK_FREQ/BAUD_RATE  clocks per bit at reset (5208)
//  DATA_BITS   8           payload bits per frame, 5..9
//  FIFO_DEPTH  16          entries per FIFO; power of 2, >=2
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  rst_n     in   1          asynchronous reset, active-low
//  Address   in   32         byte offset; only Address[2:0] decoded
//  DataIn    in   32         write data
//  DataOut   out  32         registered read data
//  Select    in   1          peripheral chip select
//  Write     in   1          1=write, 0=read (qualified by Select)
//  rx        in   1          serial input, asynchronous, idle high
//  tx        out  1          serial output, idle high
//  irq       out  1          level interrupt request
// BEHAVIOUR
//  Reset: DataOut=0, tx=1, irq=0, SETUP=0x3 (tx_en, rx_en, no parity, 1 stop), DIV=DFLT_DIV, FIFOs empty, sticky flags 0.
//  Register map, Address[2:0]:
//   0 SETUP RW  [0]tx_en [1]rx_en [3:2]parity 00 none, 01 even, 10 odd, 11 none
//               [4]two_stop [5]tx_flush* [6]rx_flush* [7]err_clr* [8]irq_rx_en [9]irq_tx_en
//               (* write-1, self-clearing, read as 0)
//   1 FLAGS RO  [0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]parity_err [5]frame_err
//               [6]overrun [7]tx_busy [15:8]rx_count [23:16]tx_count
//   2 TX    WO  push DataIn[DATA_BITS-1:0]; push while full is dropped; reads return 0
//   3 RX    RO  pop; returns head zero-extended; read while empty returns 0 and does not pop
//   4 DIV   RW  clocks per bit [15:0]; writes below 4 store 4
//   5..7        reads 0; writes ignored
//  Bus timing:
//   - Write takes effect on the posedge where Select&Write=1.
//   - Read data is valid in DataOut after the posedge where Select&!Write=1 (1-cycle latency).
//   - DataOut holds its value when Select=0.
//   - RX pop happens on that same edge; a Select held for N cycles pops N times.
//  TX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
//   - Leaves IDLE when tx_en=1 and the TX FIFO is non-empty; pops on entry to START.
//   - Each state lasts DIV clocks. DATA sends LSB first, DATA_BITS bits.
//   - PARITY is skipped when mode is none. STOP lasts 1 or 2 bit times.
//   - Frame config (DIV, parity, two_stop) is latched at START; mid-frame writes apply to the next frame.
//   - tx_en=0 mid-frame completes the current frame, then stays IDLE.
//  RX FSM IDLE->START->DATA->PARITY->STOP:
//   - rx passes through a 2-flop synchroniser first.
//   - Falling edge in IDLE enters START. At DIV/2, rx=1 returns to IDLE (glitch); otherwise sample every DIV clocks.
//   - Parity mismatch sets parity_err. STOP sampled 0 sets frame_err and the byte is discarded.
//   - A byte is pushed only on a good stop bit; rx_en=0 holds IDLE.
//   - Push while full: byte dropped, overrun set.
//  Sticky flags clear only on err_clr=1 or reset; a same-cycle set wins over clear.
//  Flush: occupancy to 0 next cycle. tx_flush does not abort the frame in flight; a same-cycle push is discarded.
//  Simultaneous push and pop on the same FIFO: both occur, count unchanged. Pop on empty/push on full are ignored as above.
//  irq = (irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty) | parity_err | frame_err | overrun.
//  Reset mid-frame aborts immediately: tx=1 and FSMs return to IDLE.
// STRUCTURE
//  Shared package uart_pkg:
//   - register offsets and SETUP/FLAGS bit indices
//   - parity mode encodings
//   - TX/RX state enums
//  Sub-module uart_sync_fifo (WIDTH, DEPTH):
//   - push/pop/flush, full/empty/count
//   - instantiated twice, for TX and RX
//  TX/RX FSMs and bit counters stay in this module.
// TESTING
//  1 DIV=8, 8N1, write TX=0xA5 -> tx low 8 clk, bits 1,0,1,0,0,1,0,1, high 8 clk; tx_empty=1 after the pop.
//  2 Loopback tx->rx, even parity, 2 stop, push 0x00,0xFF,0x5A -> RX reads return them in order; parity_err=0, rx_count counts 3->0.
//  3 Push FIFO_DEPTH+1 bytes with tx_en=0 -> tx_full=1, tx_count=16, 17th byte never transmitted.
//  4 Inject 17 frames with no RX reads -> overrun=1, first 16 bytes intact, irq=1; err_clr -> overrun=0.
//  5 Inject frame with a bad parity bit (odd mode), then one with stop=0 -> parity_err=1, frame_err=1; the stop=0 byte is not pushed.
//  6 Assert rst_n=0 mid-transmit -> tx=1 and DataOut=0 immediately, SETUP reads 0x3, DIV reads DFLT_DIV; a 2-cycle rx glitch is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Register map, bit indices, parity encodings and FSM state
//                types shared by the memory-mapped FIFO UART.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [2:0] c_REG_SETUP = 3'd0;
  localparam logic [2:0] c_REG_FLAGS = 3'd1;
  localparam logic [2:0] c_REG_TX    = 3'd2;
  localparam logic [2:0] c_REG_RX    = 3'd3;
  localparam logic [2:0] c_REG_DIV   = 3'd4;

  localparam int c_SETUP_TX_EN    = 0;
  localparam int c_SETUP_RX_EN    = 1;
  localparam int c_SETUP_PAR_LO   = 2;
  localparam int c_SETUP_PAR_HI   = 3;
  localparam int c_SETUP_TWO_STOP = 4;
  localparam int c_SETUP_TX_FLUSH = 5;
  localparam int c_SETUP_RX_FLUSH = 6;
  localparam int c_SETUP_ERR_CLR  = 7;
  localparam int c_SETUP_IRQ_RX   = 8;
  localparam int c_SETUP_IRQ_TX   = 9;

  localparam int c_FLAG_TX_FULL  = 0;
  localparam int c_FLAG_TX_EMPTY = 1;
  localparam int c_FLAG_RX_EMPTY = 2;
  localparam int c_FLAG_RX_FULL  = 3;
  localparam int c_FLAG_PAR_ERR  = 4;
  localparam int c_FLAG_FRM_ERR  = 5;
  localparam int c_FLAG_OVERRUN  = 6;
  localparam int c_FLAG_TX_BUSY  = 7;

  localparam logic [1:0] c_PAR_NONE = 2'b00;
  localparam logic [1:0] c_PAR_EVEN = 2'b01;
  localparam logic [1:0] c_PAR_ODD  = 2'b10;

  localparam logic [15:0] c_DIV_MIN = 16'd4;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == c_PAR_EVEN) || (mode == c_PAR_ODD);
  endfunction

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] data);
    return (^data) ^ (mode == c_PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mmio_if
//  Description : Single-cycle core data-bus slice seen by the UART peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_fifo_mmio_if;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Select;
  logic        Write;

  modport master (output Address, DataIn, Select, Write, input DataOut);
  modport slave  (input Address, DataIn, Select, Write, output DataOut);
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Synchronous FIFO with flush and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_push,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  input  wire logic [WIDTH-1:0]         i_wdata,
  output logic      [WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mmio
//  Description : Memory-mapped full-duplex UART with TX/RX FIFOs, parity,
//                configurable stop bits, sticky errors and interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int DFLT_DIV   = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_fifo_mmio_if.slave   bus,
  input  wire logic         rx,
  output logic              tx,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] c_DFLT_DIV = 16'(DFLT_DIV);
  localparam logic [3:0]  c_LAST_BIT = 4'(DATA_BITS - 1);

  // Configuration and status registers
  logic        r_tx_en, r_rx_en, r_two_stop, r_irq_rx_en, r_irq_tx_en;
  logic [1:0]  r_parity;
  logic [15:0] r_div;
  logic        r_perr, r_ferr, r_ovr;
  logic [31:0] r_dout;
  logic [31:0] w_rdata;

  logic [2:0]  w_addr;
  logic        w_wr, w_rd, w_setup_wr;
  logic        w_tx_flush, w_rx_flush, w_err_clr, w_tx_push, w_rx_pop;
  logic        w_unused;

  // FIFO interfaces
  logic [DATA_BITS-1:0] w_txf_rdata, w_rxf_rdata;
  logic                 w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
  logic [CW:0]          w_txf_count, w_rxf_count;
  logic                 w_tx_pop, w_rx_push;

  // TX FSM
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [15:0]          r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
  logic [3:0]           r_tx_bit, w_tx_bit_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [1:0]           r_tx_par_mode, w_tx_par_mode_nxt;
  logic                 r_tx_par_bit, w_tx_par_bit_nxt;
  logic                 r_tx_two_stop, w_tx_two_stop_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_tx_bit_done;

  // RX FSM
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [15:0]          r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
  logic [3:0]           r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [1:0]           r_rx_par_mode, w_rx_par_mode_nxt;
  logic                 w_rx_bit_done, w_rx_fall;
  logic                 w_perr_set, w_ferr_set, w_ovr_set;

  assign w_addr     = bus.Address[2:0];
  assign w_wr       = bus.Select & bus.Write;
  assign w_rd       = bus.Select & ~bus.Write;
  assign w_setup_wr = w_wr && (w_addr == c_REG_SETUP);
  assign w_tx_flush = w_setup_wr & bus.DataIn[c_SETUP_TX_FLUSH];
  assign w_rx_flush = w_setup_wr & bus.DataIn[c_SETUP_RX_FLUSH];
  assign w_err_clr  = w_setup_wr & bus.DataIn[c_SETUP_ERR_CLR];
  assign w_tx_push  = w_wr && (w_addr == c_REG_TX);
  assign w_rx_pop   = w_rd && (w_addr == c_REG_RX);
  assign w_unused   = ^{bus.Address[31:3], bus.DataIn[31:16]};

  assign bus.DataOut = r_dout;
  assign tx          = r_tx;
  assign irq = (r_irq_rx_en & ~w_rxf_empty) | (r_irq_tx_en & w_txf_empty)
             | r_perr | r_ferr | r_ovr;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_flush(w_tx_flush),
    .i_wdata(bus.DataIn[DATA_BITS-1:0]), .o_rdata(w_txf_rdata), .o_full(w_txf_full),
    .o_empty(w_txf_empty), .o_count(w_txf_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_flush(w_rx_flush),
    .i_wdata(r_rx_shift), .o_rdata(w_rxf_rdata), .o_full(w_rxf_full),
    .o_empty(w_rxf_empty), .o_count(w_rxf_count)
  );

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      c_REG_SETUP: w_rdata = {22'd0, r_irq_tx_en, r_irq_rx_en, 3'd0, r_two_stop,
                              r_parity, r_rx_en, r_tx_en};
      c_REG_FLAGS: w_rdata = {8'd0, 8'(w_txf_count), 8'(w_rxf_count),
                              (r_tx_state != TX_IDLE), r_ovr, r_ferr, r_perr,
                              w_rxf_full, w_rxf_empty, w_txf_empty, w_txf_full};
      c_REG_RX:    w_rdata = w_rxf_empty ? 32'd0 : 32'(w_rxf_rdata);
      c_REG_DIV:   w_rdata = {16'd0, r_div};
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en     <= 1'b1;
      r_rx_en     <= 1'b1;
      r_parity    <= c_PAR_NONE;
      r_two_stop  <= 1'b0;
      r_irq_rx_en <= 1'b0;
      r_irq_tx_en <= 1'b0;
      r_div       <= c_DFLT_DIV;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_ovr       <= 1'b0;
      r_dout      <= '0;
    end else begin
      if (w_setup_wr) begin
        r_tx_en     <= bus.DataIn[c_SETUP_TX_EN];
        r_rx_en     <= bus.DataIn[c_SETUP_RX_EN];
        r_parity    <= bus.DataIn[c_SETUP_PAR_HI:c_SETUP_PAR_LO];
        r_two_stop  <= bus.DataIn[c_SETUP_TWO_STOP];
        r_irq_rx_en <= bus.DataIn[c_SETUP_IRQ_RX];
        r_irq_tx_en <= bus.DataIn[c_SETUP_IRQ_TX];
      end
      if (w_wr && (w_addr == c_REG_DIV))
        r_div <= (bus.DataIn[15:0] < c_DIV_MIN) ? c_DIV_MIN : bus.DataIn[15:0];
      // A new error in the same cycle as err_clr must survive
      r_perr <= w_perr_set | (r_perr & ~w_err_clr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_err_clr);
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_err_clr);
      if (w_rd) r_dout <= w_rdata;
    end
  end

  assign w_tx_bit_done = (r_tx_cnt == r_tx_div - 16'd1);

  always_comb begin
    w_tx_state_nxt    = r_tx_state;
    w_tx_cnt_nxt      = r_tx_cnt + 16'd1;
    w_tx_div_nxt      = r_tx_div;
    w_tx_bit_nxt      = r_tx_bit;
    w_tx_shift_nxt    = r_tx_shift;
    w_tx_par_mode_nxt = r_tx_par_mode;
    w_tx_par_bit_nxt  = r_tx_par_bit;
    w_tx_two_stop_nxt = r_tx_two_stop;
    w_tx_nxt          = r_tx;
    w_tx_pop          = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (r_tx_en && !w_txf_empty) begin
          w_tx_state_nxt    = TX_START;
          w_tx_pop          = 1'b1;
          w_tx_shift_nxt    = w_txf_rdata;
          w_tx_div_nxt      = r_div;
          w_tx_par_mode_nxt = r_parity;
          w_tx_par_bit_nxt  = parity_bit(r_parity, 9'(w_txf_rdata));
          w_tx_two_stop_nxt = r_two_stop;
          w_tx_nxt          = 1'b0;
        end
      end
      TX_START: if (w_tx_bit_done) begin
        w_tx_state_nxt = TX_DATA;
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = '0;
        w_tx_nxt       = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_done) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_bit == c_LAST_BIT) begin
          w_tx_bit_nxt = '0;
          if (parity_enabled(r_tx_par_mode)) begin
            w_tx_state_nxt = TX_PARITY;
            w_tx_nxt       = r_tx_par_bit;
          end else begin
            w_tx_state_nxt = TX_STOP;
            w_tx_nxt       = 1'b1;
          end
        end else begin
          w_tx_bit_nxt   = r_tx_bit + 4'd1;
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_nxt       = r_tx_shift[1];
        end
      end
      TX_PARITY: if (w_tx_bit_done) begin
        w_tx_state_nxt = TX_STOP;
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = '0;
        w_tx_nxt       = 1'b1;
      end
      TX_STOP: if (w_tx_bit_done) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_two_stop && (r_tx_bit == 4'd0)) w_tx_bit_nxt = 4'd1;
        else w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state    <= TX_IDLE;
      r_tx_cnt      <= '0;
      r_tx_div      <= c_DFLT_DIV;
      r_tx_bit      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_mode <= c_PAR_NONE;
      r_tx_par_bit  <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_tx          <= 1'b1;
    end else begin
      r_tx_state    <= w_tx_state_nxt;
      r_tx_cnt      <= w_tx_cnt_nxt;
      r_tx_div      <= w_tx_div_nxt;
      r_tx_bit      <= w_tx_bit_nxt;
      r_tx_shift    <= w_tx_shift_nxt;
      r_tx_par_mode <= w_tx_par_mode_nxt;
      r_tx_par_bit  <= w_tx_par_bit_nxt;
      r_tx_two_stop <= w_tx_two_stop_nxt;
      r_tx          <= w_tx_nxt;
    end
  end

  assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
  assign w_rx_bit_done = (r_rx_cnt == r_rx_div - 16'd1);
  assign w_ovr_set     = w_rx_push & w_rxf_full & ~w_rx_pop;

  always_comb begin
    w_rx_state_nxt    = r_rx_state;
    w_rx_cnt_nxt      = r_rx_cnt + 16'd1;
    w_rx_div_nxt      = r_rx_div;
    w_rx_bit_nxt      = r_rx_bit;
    w_rx_shift_nxt    = r_rx_shift;
    w_rx_par_mode_nxt = r_rx_par_mode;
    w_rx_push         = 1'b0;
    w_perr_set        = 1'b0;
    w_ferr_set        = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_en && w_rx_fall) begin
          w_rx_state_nxt    = RX_START;
          w_rx_div_nxt      = r_div;
          w_rx_par_mode_nxt = r_parity;
        end
      end
      // Mid-start-bit check; a line back high means the edge was a glitch
      RX_START: if (r_rx_cnt == (r_rx_div >> 1)) begin
        w_rx_cnt_nxt   = '0;
        w_rx_bit_nxt   = '0;
        w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_rx_bit_done) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_bit == c_LAST_BIT)
          w_rx_state_nxt = parity_enabled(r_rx_par_mode) ? RX_PARITY : RX_STOP;
        else
          w_rx_bit_nxt = r_rx_bit + 4'd1;
      end
      RX_PARITY: if (w_rx_bit_done) begin
        w_rx_cnt_nxt   = '0;
        w_perr_set     = (r_rx_s2 != parity_bit(r_rx_par_mode, 9'(r_rx_shift)));
        w_rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (w_rx_bit_done) begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = RX_IDLE;
        w_rx_push      = r_rx_s2;
        w_ferr_set     = ~r_rx_s2;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1       <= 1'b1;
      r_rx_s2       <= 1'b1;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_div      <= c_DFLT_DIV;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_par_mode <= c_PAR_NONE;
    end else begin
      r_rx_s1       <= rx;
      r_rx_s2       <= r_rx_s1;
      r_rx_prev     <= r_rx_s2;
      r_rx_state    <= w_rx_state_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_rx_div      <= w_rx_div_nxt;
      r_rx_bit      <= w_rx_bit_nxt;
      r_rx_shift    <= w_rx_shift_nxt;
      r_rx_par_mode <= w_rx_par_mode_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo_mmio
//  Description : Directed self-checking bench for uart_fifo_mmio with a byte
//                scoreboard between stimulus and RX reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_fifo_mmio;
  import uart_pkg::*;

  localparam int BIT  = 8;
  localparam int DFLT = 50_000_000 / 9_600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_inj = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line;
  logic tx, irq;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  uart_fifo_mmio_if bus();

  uart_fifo_mmio #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(9_600), .DATA_BITS(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .rx(rx_line), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always_comb rx_line = loop_en ? tx : rx_inj;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Address = {29'd0, a}; bus.DataIn = d; bus.Select = 1'b1; bus.Write = 1'b1;
    @(negedge clk);
    bus.Select = 1'b0; bus.Write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.Address = {29'd0, a}; bus.Select = 1'b1; bus.Write = 1'b0;
    @(negedge clk);
    bus.Select = 1'b0;
    d = bus.DataOut;
  endtask

  task automatic wait_rx_count(input int n, input int max_polls, input string tag);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < max_polls; i++) begin
      bus_read(c_REG_FLAGS, f);
      if (f[15:8] == 8'(n)) break;
    end
    chk(tag, {24'd0, f[15:8]}, 32'(n));
  endtask

  task automatic read_rx_expect(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    e = exp_q.pop_front();
    bus_read(c_REG_RX, d);
    chk(tag, d, {24'd0, e});
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx_inj = b;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] par,
                            input bit bad_par, input bit bad_stop);
    logic p;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par == 2'b01 || par == 2'b10) begin
      p = ^d;
      if (par == 2'b10) p = ~p;
      if (bad_par) p = ~p;
      drive_bit(p);
    end
    drive_bit(~bad_stop);
    drive_bit(1'b1);
  endtask

  // Samples tx for one bit time and counts samples that differ from b
  task automatic expect_tx_bit(input logic b, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < BIT; i++) begin
      if (tx !== b) bad++;
      @(negedge clk);
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (tx === 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  tx_byte;
    bus.Address = '0; bus.DataIn = '0; bus.Select = 1'b0; bus.Write = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset DataOut", bus.DataOut, 32'd0);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    bus_read(c_REG_SETUP, d); chk("reset SETUP", d, 32'h3);
    bus_read(c_REG_DIV, d);   chk("reset DIV", d, 32'(DFLT));
    bus_read(c_REG_FLAGS, d); chk("reset FLAGS", d, 32'h6);
    bus_write(c_REG_DIV, 32'd2);
    bus_read(c_REG_DIV, d);   chk("DIV min clamp", d, 32'd4);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, d);        chk("unmapped read", d, 32'd0);
    bus_read(c_REG_RX, d);    chk("RX read when empty", d, 32'd0);

    // 1: 8N1 frame timing on the wire
    bus_write(c_REG_DIV, 32'(BIT));
    tx_byte = 8'hA5;
    bus_write(c_REG_TX, {24'd0, tx_byte});
    wait_tx_low(20, "tx start seen");
    expect_tx_bit(1'b0, "tx start bit");
    for (int i = 0; i < 8; i++) expect_tx_bit(tx_byte[i], $sformatf("tx data bit %0d", i));
    expect_tx_bit(1'b1, "tx stop bit");
    bus_read(c_REG_FLAGS, d); chk("FLAGS after frame", d, 32'h6);

    // 2: loopback, even parity, two stop bits
    bus_write(c_REG_SETUP, 32'h17 | 32'h40);
    loop_en = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h5A);
    bus_write(c_REG_TX, 32'h00);
    bus_write(c_REG_TX, 32'hFF);
    bus_write(c_REG_TX, 32'h5A);
    wait_rx_count(3, 400, "loopback rx_count 3");
    bus_read(c_REG_FLAGS, d); chk("loopback errors", {29'd0, d[6:4]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      read_rx_expect($sformatf("loopback byte %0d", i));
      bus_read(c_REG_FLAGS, d); chk($sformatf("rx_count after pop %0d", i), {24'd0, d[15:8]}, 32'(2 - i));
    end
    repeat (40) @(negedge clk);
    loop_en = 1'b0;

    // 3: TX FIFO fill with transmitter disabled
    bus_write(c_REG_SETUP, 32'h2 | 32'h40 | 32'h20);
    for (int i = 0; i < 17; i++) begin
      bus_write(c_REG_TX, 32'(8'(i * 7 + 3)));
      if (i < 16) exp_q.push_back(8'(i * 7 + 3));
    end
    bus_read(c_REG_FLAGS, d);
    chk("tx_full", {31'd0, d[c_FLAG_TX_FULL]}, 32'd1);
    chk("tx_count full", {24'd0, d[23:16]}, 32'd16);
    loop_en = 1'b1;
    bus_write(c_REG_SETUP, 32'h3);
    wait_rx_count(16, 1200, "drained 16 frames");
    for (int i = 0; i < 16; i++) read_rx_expect($sformatf("fifo byte %0d", i));
    repeat (40) @(negedge clk);
    bus_read(c_REG_FLAGS, d); chk("17th byte not sent", d, 32'h6);
    loop_en = 1'b0;

    // 4: RX overrun
    bus_write(c_REG_SETUP, 32'h3 | 32'h40 | 32'h80);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h30 + i), 2'b00, 1'b0, 1'b0);
      if (i < 16) exp_q.push_back(8'(8'h30 + i));
    end
    bus_read(c_REG_FLAGS, d); chk("overrun flags", {16'd0, d[15:0]}, 32'h104A);
    chk("irq on overrun", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 16; i++) read_rx_expect($sformatf("overrun byte %0d", i));
    bus_write(c_REG_SETUP, 32'h3 | 32'h80);
    bus_read(c_REG_FLAGS, d); chk("overrun cleared", d, 32'h6);
    chk("irq after clear", {31'd0, irq}, 32'd0);

    // 5: parity error then framing error, odd parity
    bus_write(c_REG_SETUP, 32'hB | 32'h40 | 32'h80);
    send_frame(8'h3C, 2'b10, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    bus_read(c_REG_FLAGS, d); chk("parity_err flags", {16'd0, d[15:0]}, 32'h0112);
    send_frame(8'h11, 2'b10, 1'b0, 1'b1);
    bus_read(c_REG_FLAGS, d); chk("frame_err flags", {16'd0, d[15:0]}, 32'h0132);
    chk("irq on errors", {31'd0, irq}, 32'd1);
    read_rx_expect("parity-err byte kept");
    bus_read(c_REG_FLAGS, d); chk("bad-stop byte dropped", {31'd0, d[c_FLAG_RX_EMPTY]}, 32'd1);

    // 6: reset mid-transmit, then a short rx glitch
    bus_write(c_REG_SETUP, 32'h3 | 32'h80);
    bus_write(c_REG_TX, 32'h55);
    wait_tx_low(20, "tx start before reset");
    repeat (20) @(negedge clk);
    bus_read(c_REG_FLAGS, d); chk("busy before reset", d, 32'h86);
    @(negedge clk);
    chk("tx low before reset", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tx after reset", {31'd0, tx}, 32'd1);
    chk("DataOut after reset", bus.DataOut, 32'd0);
    chk("irq after reset", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(c_REG_SETUP, d); chk("SETUP after reset", d, 32'h3);
    bus_read(c_REG_DIV, d);   chk("DIV after reset", d, 32'(DFLT));
    bus_write(c_REG_DIV, 32'(BIT));
    @(negedge clk); rx_inj = 1'b0;
    repeat (2) @(negedge clk); rx_inj = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(c_REG_FLAGS, d); chk("glitch ignored", d, 32'h6);
    chk("tx idle after reset", {31'd0, tx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
